// File: rtl/led_frame_fetcher.sv
`default_nettype none
// ============================================================================
//  Module   : led_frame_fetcher
//  Purpose  : Read-side scheduler for the LED frame buffer. Walks the frame in
//             RAM row by row and issues byte reads on one arbiter requester
//             port, with a bounded number of reads in flight. Returned bytes
//             fill one half of a ping-pong row buffer. Completed rows are
//             handed to the HUB75 scan driver with a valid/done handshake.
//  Ports    :
//    clk, reset           system clock; synchronous active-high reset
//    enable               run the fetch loop
//    frame_base           frame buffer start address, sampled at row 0
//    mem_address          read request address (registered)
//    mem_wr, mem_data     write path, tied to 0 (read-only requester)
//    mem_data_in_ready    one-cycle request strobe (registered)
//    mem_fifo_full        arbiter backpressure for this port
//    mem_data_out         returned byte
//    mem_data_out_ready   returned byte valid
//    disp_row_valid       display bank holds a complete row (registered)
//    disp_row             row index held by the display bank (registered)
//    disp_rd_addr         byte index read by the display side
//    disp_rd_data         display bank byte, one cycle after disp_rd_addr
//    disp_row_done        display has released its bank (one-cycle pulse)
//    frame_done           one-cycle pulse when the last row of a frame lands
//  Revision : 1.0  initial release
// ============================================================================
module led_frame_fetcher #(
  parameter int ADDRESS_WIDTH   = 25,
  parameter int COLUMNS         = 64,
  parameter int ROWS            = 32,
  parameter int BYTES_PER_PIXEL = 3,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                                        clk,
  input  logic                                        reset,
  input  logic                                        enable,
  input  logic [ADDRESS_WIDTH-1:0]                    frame_base,
  output logic [ADDRESS_WIDTH-1:0]                    mem_address,
  output logic                                        mem_wr,
  output logic [7:0]                                  mem_data,
  output logic                                        mem_data_in_ready,
  input  logic                                        mem_fifo_full,
  input  logic [7:0]                                  mem_data_out,
  input  logic                                        mem_data_out_ready,
  output logic                                        disp_row_valid,
  output logic [$clog2(ROWS)-1:0]                     disp_row,
  input  logic [$clog2(COLUMNS*BYTES_PER_PIXEL)-1:0]  disp_rd_addr,
  output logic [7:0]                                  disp_rd_data,
  input  logic                                        disp_row_done,
  output logic                                        frame_done
);

  localparam int ROW_BYTES = COLUMNS * BYTES_PER_PIXEL;
  localparam int ROW_W     = $clog2(ROWS);
  localparam int IDX_W     = $clog2(ROW_BYTES + 1);   // must hold ROW_BYTES itself
  localparam int CRD_W     = $clog2(MAX_OUTSTANDING + 1);
  localparam int BUF_DEPTH = 2 * ROW_BYTES;
  localparam int BUF_AW    = $clog2(BUF_DEPTH);

  localparam logic [IDX_W-1:0]         C_ROW_BYTES  = IDX_W'(ROW_BYTES);
  localparam logic [IDX_W-1:0]         C_LAST_IDX   = IDX_W'(ROW_BYTES - 1);
  localparam logic [CRD_W-1:0]         C_MAX_OUT    = CRD_W'(MAX_OUTSTANDING);
  localparam logic [ROW_W-1:0]         C_LAST_ROW   = ROW_W'(ROWS - 1);
  localparam logic [ADDRESS_WIDTH-1:0] C_ROW_STRIDE = ADDRESS_WIDTH'(ROW_BYTES);
  localparam logic [BUF_AW-1:0]        C_BANK1_OFS  = BUF_AW'(ROW_BYTES);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_FETCH     = 2'd1,
    ST_WAIT_BANK = 2'd2
  } state_t;

  state_t state;
  state_t next_state;

  logic                     r_fill_bank;
  logic [ROW_W-1:0]         r_row;
  logic [ADDRESS_WIDTH-1:0] r_row_base;
  logic [IDX_W-1:0]         r_req_idx;
  logic [IDX_W-1:0]         r_ret_idx;
  logic [CRD_W-1:0]         r_outstanding;
  logic [7:0]               r_row_buf [BUF_DEPTH];

  logic                     w_start;
  logic                     w_issue;
  logic                     w_ret_accept;
  logic                     w_swap;
  logic [BUF_AW-1:0]        w_wr_ptr;
  logic [BUF_AW-1:0]        w_rd_ptr;
  logic                     w_rd_in_range;

  assign mem_wr   = 1'b0;
  assign mem_data = 8'd0;

  // A return with nothing in flight cannot belong to us; drop it.
  assign w_ret_accept = mem_data_out_ready && (r_outstanding != '0);

  // Bank 0 occupies buffer entries [0, ROW_BYTES), bank 1 the next ROW_BYTES.
  // The fill side writes r_fill_bank, the display side reads the other one.
  assign w_wr_ptr      = r_fill_bank ? (C_BANK1_OFS + BUF_AW'(r_ret_idx)) : BUF_AW'(r_ret_idx);
  assign w_rd_ptr      = r_fill_bank ? BUF_AW'(disp_rd_addr) : (C_BANK1_OFS + BUF_AW'(disp_rd_addr));
  assign w_rd_in_range = BUF_AW'(disp_rd_addr) < C_BANK1_OFS;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and control strobes
  // --------------------------------------------------------------------------
  always_comb begin
    next_state = state;
    w_start    = 1'b0;
    w_issue    = 1'b0;
    w_swap     = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (enable) begin
          w_start    = 1'b1;
          next_state = ST_FETCH;
        end
      end

      ST_FETCH: begin
        w_issue = (r_req_idx < C_ROW_BYTES) &&
                  (r_outstanding < C_MAX_OUT) &&
                  !mem_fifo_full;
        if (w_ret_accept && (r_ret_idx == C_LAST_IDX)) begin
          // Final byte of the row: hand it over now if the display bank is
          // free (or being freed this very cycle), otherwise park.
          if (!disp_row_valid || disp_row_done) begin
            w_swap     = 1'b1;
            next_state = enable ? ST_FETCH : ST_IDLE;
          end else begin
            next_state = ST_WAIT_BANK;
          end
        end
      end

      ST_WAIT_BANK: begin
        if (disp_row_done) begin
          w_swap     = 1'b1;
          next_state = enable ? ST_FETCH : ST_IDLE;
        end
      end

      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Row buffer write port. No reset: contents are only exposed after a full
  // row has been written.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset && w_ret_accept) begin
      r_row_buf[w_wr_ptr] <= mem_data_out;
    end
  end

  // --------------------------------------------------------------------------
  // Datapath: request generation, credit counter, row sequencing, handshake
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_fill_bank       <= 1'b0;
      r_row             <= '0;
      r_row_base        <= '0;
      r_req_idx         <= '0;
      r_ret_idx         <= '0;
      r_outstanding     <= '0;
      mem_address       <= '0;
      mem_data_in_ready <= 1'b0;
      disp_row_valid    <= 1'b0;
      disp_row          <= '0;
      frame_done        <= 1'b0;
      disp_rd_data      <= 8'd0;
    end else begin
      mem_data_in_ready <= w_issue;
      frame_done        <= 1'b0;
      disp_rd_data      <= w_rd_in_range ? r_row_buf[w_rd_ptr] : 8'd0;

      if (w_issue) begin
        mem_address <= r_row_base + ADDRESS_WIDTH'(r_req_idx);
        r_req_idx   <= r_req_idx + IDX_W'(1);
      end

      // Issue and return in the same cycle cancel out.
      unique case ({w_issue, w_ret_accept})
        2'b10:   r_outstanding <= r_outstanding + CRD_W'(1);
        2'b01:   r_outstanding <= r_outstanding - CRD_W'(1);
        default: r_outstanding <= r_outstanding;
      endcase

      if (w_ret_accept) begin
        r_ret_idx <= r_ret_idx + IDX_W'(1);
      end

      if (w_start) begin
        r_row      <= '0;
        r_row_base <= frame_base;
        r_req_idx  <= '0;
        r_ret_idx  <= '0;
      end

      if (w_swap) begin
        r_fill_bank    <= ~r_fill_bank;
        disp_row_valid <= 1'b1;
        disp_row       <= r_row;
        r_req_idx      <= '0;
        r_ret_idx      <= '0;
        if (r_row == C_LAST_ROW) begin
          r_row      <= '0;
          r_row_base <= frame_base;
          frame_done <= 1'b1;
        end else begin
          r_row      <= r_row + ROW_W'(1);
          r_row_base <= r_row_base + C_ROW_STRIDE;
        end
      end else if (disp_row_done) begin
        disp_row_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_led_frame_fetcher.sv
`default_nettype none
// ============================================================================
//  Module   : tb_led_frame_fetcher
//  Purpose  : Self-checking bench for led_frame_fetcher. A fixed-latency
//             arbiter model returns bytes derived from their address; a
//             reference model of the frame walk predicts every request
//             address and every row hand-over.
//  Revision : 1.0  initial release
// ============================================================================
module tb_led_frame_fetcher;

  localparam int AW        = 25;
  localparam int ROW_BYTES = 192;
  localparam int NROWS     = 32;
  localparam int LAT       = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic [AW-1:0] frame_base;
  logic [AW-1:0] mem_address;
  logic          mem_wr;
  logic [7:0]    mem_data;
  logic          mem_data_in_ready;
  logic          mem_fifo_full;
  logic [7:0]    mem_data_out = 8'd0;
  logic          mem_data_out_ready = 1'b0;
  logic          disp_row_valid;
  logic [4:0]    disp_row;
  logic [7:0]    disp_rd_addr;
  logic [7:0]    disp_rd_data;
  logic          disp_row_done;
  logic          frame_done;

  always #5 clk = ~clk;

  led_frame_fetcher dut (
    .clk                (clk),
    .reset              (reset),
    .enable             (enable),
    .frame_base         (frame_base),
    .mem_address        (mem_address),
    .mem_wr             (mem_wr),
    .mem_data           (mem_data),
    .mem_data_in_ready  (mem_data_in_ready),
    .mem_fifo_full      (mem_fifo_full),
    .mem_data_out       (mem_data_out),
    .mem_data_out_ready (mem_data_out_ready),
    .disp_row_valid     (disp_row_valid),
    .disp_row           (disp_row),
    .disp_rd_addr       (disp_rd_addr),
    .disp_rd_data       (disp_rd_data),
    .disp_row_done      (disp_row_done),
    .frame_done         (frame_done)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", name, got, exp);
    end
  endtask

  // Frame buffer contents as seen through the arbiter.
  function automatic logic [7:0] mem_byte(input logic [AW-1:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  // ---------------------------------------------------------------- model
  int            req_cnt;          // requests seen since time zero
  int            m_req_row, m_req_k, m_req_rows_total;
  int            m_ret_row, m_ret_k, rows_filled;
  int            swaps_total, outst, frame_done_cnt, last_swap_row;
  logic [AW-1:0] m_fb;
  logic [AW-1:0] exp_addr;
  logic [AW-1:0] addr_k64;
  logic          prev_valid;
  int            comp_q[$];
  int            popped;
  logic          pv [LAT];
  logic [AW-1:0] pa [LAT];
  logic          ret_v;
  logic [AW-1:0] ret_a;

  initial req_cnt = 0;

  always @(posedge clk) begin
    #1;
    if (reset) begin
      m_req_row = 0; m_req_k = 0; m_req_rows_total = 0;
      m_ret_row = 0; m_ret_k = 0; rows_filled = 0;
      swaps_total = 0; outst = 0; frame_done_cnt = 0; last_swap_row = -1;
      m_fb = '0; addr_k64 = 25'h1555555; prev_valid = 1'b0;
      comp_q.delete();
      for (int i = 0; i < LAT; i++) begin pv[i] = 1'b0; pa[i] = '0; end
      mem_data_out_ready = 1'b0;
      mem_data_out       = 8'd0;
    end else begin
      check("mem_wr_zero", mem_wr, 0);
      check("mem_data_zero", mem_data, 0);

      // Request stream: strictly sequential walk of the frame.
      if (mem_data_in_ready) begin
        req_cnt++;
        if (m_req_row == 0 && m_req_k == 0) m_fb = frame_base;
        if (m_req_k == 0) check("row_start_after_swap", swaps_total, m_req_rows_total);
        exp_addr = m_fb + AW'(m_req_row * ROW_BYTES + m_req_k);
        check("req_addr", mem_address, exp_addr);
        check("req_while_full", mem_fifo_full, 0);
        if (m_req_row == 0 && m_req_k == 64) addr_k64 = mem_address;
        outst++;
        check("credit_limit", outst <= 4, 1);
        m_req_k++;
        if (m_req_k == ROW_BYTES) begin
          m_req_k = 0;
          m_req_row = (m_req_row + 1) % NROWS;
          m_req_rows_total++;
        end
      end

      // Row hand-over: valid rises, or stays up across a release pulse.
      if (disp_row_valid && (!prev_valid || disp_row_done)) begin
        if (comp_q.size() == 0) begin
          check("swap_without_filled_row", 1, 0);
        end else begin
          popped = comp_q.pop_front();
          check("disp_row", disp_row, popped);
          check("frame_done_on_last_row", frame_done, popped == NROWS - 1);
          swaps_total++;
          last_swap_row = popped;
        end
      end else begin
        check("frame_done_spurious", frame_done, 0);
      end
      if (frame_done) frame_done_cnt++;
      prev_valid = disp_row_valid;

      // Arbiter: fixed latency, returns in order.
      ret_v = pv[LAT-1];
      ret_a = pa[LAT-1];
      for (int i = LAT - 1; i > 0; i--) begin pv[i] = pv[i-1]; pa[i] = pa[i-1]; end
      pv[0] = mem_data_in_ready;
      pa[0] = mem_address;
      mem_data_out_ready = ret_v;
      mem_data_out       = ret_v ? mem_byte(ret_a) : 8'd0;
      if (ret_v) begin
        outst--;
        m_ret_k++;
        if (m_ret_k == ROW_BYTES) begin
          m_ret_k = 0;
          comp_q.push_back(m_ret_row);
          m_ret_row = (m_ret_row + 1) % NROWS;
          rows_filled++;
        end
      end
    end
  end

  // ------------------------------------------------------------- stimulus
  int cyc = 0;
  logic auto_ack;
  int s0;

  task automatic tick();
    @(posedge clk);
    #2;
    cyc++;
    disp_row_done = auto_ack && disp_row_valid && (cyc % 37 == 0);
  endtask

  task automatic do_reset();
    enable = 1'b0; auto_ack = 1'b0; mem_fifo_full = 1'b0; disp_row_done = 1'b0;
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; frame_base = '0; mem_fifo_full = 1'b0;
    disp_rd_addr = 8'd0; disp_row_done = 1'b0; auto_ack = 1'b0;
    tick(); tick();
    check("rst_req", mem_data_in_ready, 0);
    check("rst_addr", mem_address, 0);
    check("rst_valid", disp_row_valid, 0);
    check("rst_row", disp_row, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_rd_data", disp_rd_data, 0);

    // ---- row 0 at 0x100, first request timing
    reset = 1'b0; frame_base = 25'h100; enable = 1'b1;
    tick(); check("first_req_not_early", mem_data_in_ready, 0);
    tick(); check("first_req", mem_data_in_ready, 1);
    check("first_addr", mem_address, 25'h100);

    // ---- backpressure mid-row
    for (int i = 0; i < 2000 && req_cnt < 60; i++) tick();
    check("reach_60_requests", req_cnt >= 60, 1);
    mem_fifo_full = 1'b1; s0 = req_cnt;
    repeat (10) tick();
    check("no_req_while_full", req_cnt - s0, 0);
    mem_fifo_full = 1'b0;

    // ---- row 0 handed over, readback
    for (int i = 0; i < 2000 && !disp_row_valid; i++) tick();
    check("row0_valid", disp_row_valid, 1);
    check("row0_index", disp_row, 0);
    disp_rd_addr = 8'd5; tick();
    check("rd_row0_b5", disp_rd_data, 8'h5E);
    disp_rd_addr = 8'd191; tick();
    check("rd_row0_b191", disp_rd_data, 8'hE4);

    // ---- display never releases: row 1 fills and parks
    for (int i = 0; i < 2000 && rows_filled < 2; i++) tick();
    check("row1_filled", rows_filled, 2);
    repeat (3) tick();
    s0 = req_cnt;
    repeat (20) tick();
    check("wait_bank_no_req", req_cnt - s0, 0);
    check("wait_bank_row", disp_row, 0);
    disp_row_done = 1'b1; tick();
    check("swap_valid", disp_row_valid, 1);
    check("swap_row", disp_row, 1);
    disp_rd_addr = 8'd0; tick();
    check("row2_first_req", mem_data_in_ready, 1);
    check("row2_first_addr", mem_address, 25'h280);
    tick();
    check("rd_row1_b0", disp_rd_data, 8'h9B);

    // ---- full frame with address wrap
    do_reset();
    frame_base = 25'h1FFFFC0; enable = 1'b1; auto_ack = 1'b1;
    for (int i = 0; i < 12000 && frame_done_cnt < 1; i++) tick();
    check("frame_done_seen", frame_done_cnt, 1);
    for (int i = 0; i < 60 && !mem_data_in_ready; i++) tick();
    check("frame2_first_addr", mem_address, 25'h1FFFFC0);
    check("wrap_addr_k64", addr_k64, 25'h0);
    repeat (300) tick();
    check("frame_done_once", frame_done_cnt, 1);

    // ---- enable dropped mid-row 3
    do_reset();
    frame_base = 25'h100; enable = 1'b1; auto_ack = 1'b1;
    for (int i = 0; i < 3000 && !(m_req_row == 3 && m_req_k >= 50); i++) tick();
    check("reach_row3", m_req_row == 3 && m_req_k >= 50, 1);
    enable = 1'b0;
    for (int i = 0; i < 1000 && last_swap_row != 3; i++) tick();
    check("row3_shown", last_swap_row, 3);
    auto_ack = 1'b0; s0 = req_cnt;
    repeat (40) tick();
    check("idle_no_req", req_cnt - s0, 0);
    check("row3_all_requested", m_req_rows_total, 4);
    check("idle_disp_row", disp_row, 3);

    // ---- reset mid-row 2
    do_reset();
    frame_base = 25'h100; enable = 1'b1; auto_ack = 1'b1;
    for (int i = 0; i < 3000 && !(m_req_row == 2 && m_req_k >= 30); i++) tick();
    check("reach_row2", m_req_row == 2 && m_req_k >= 30, 1);
    reset = 1'b1; auto_ack = 1'b0; tick();
    check("midrst_req", mem_data_in_ready, 0);
    check("midrst_addr", mem_address, 0);
    check("midrst_valid", disp_row_valid, 0);
    check("midrst_row", disp_row, 0);
    check("midrst_frame_done", frame_done, 0);
    check("midrst_rd_data", disp_rd_data, 0);
    reset = 1'b0; tick();
    check("restart_not_early", mem_data_in_ready, 0);
    tick();
    check("restart_req", mem_data_in_ready, 1);
    check("restart_addr", mem_address, 25'h100);
    for (int i = 0; i < 2000 && !disp_row_valid; i++) tick();
    check("restart_row0_valid", disp_row_valid, 1);
    check("restart_row0_index", disp_row, 0);
    disp_rd_addr = 8'd5; tick();
    check("restart_rd_b5", disp_rd_data, 8'h5E);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/led_frame_fetcher.md
# led_frame_fetcher

Read-side scheduler that walks the LED frame buffer in RAM and fills a ping-pong row buffer for the matrix scan driver. It owns one requester port of the memory arbiter and issues byte read requests there with a bounded number of reads outstanding. It collects the returned bytes in request order and hands complete rows to the display side with a valid/done handshake. It sits between the memory arbiter and the HUB75 row driver.

## Interface
- ADDRESS_WIDTH, 25, byte address width; matches the arbiter.
- COLUMNS, 64, pixels per row.
- ROWS, 32, rows per frame.
- BYTES_PER_PIXEL, 3, bytes per pixel. ROW_BYTES = COLUMNS*BYTES_PER_PIXEL (192).
- MAX_OUTSTANDING, 4, read credit limit. It must be less than the arbiter per-peripheral FIFO depth minus 1.
- clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  run the fetch loop.
- frame_base  in  ADDRESS_WIDTH  frame buffer start address; sampled when row 0 starts.
- mem_address  out  ADDRESS_WIDTH  request address.
- mem_wr  out  1  tied 0; this block only reads.
- mem_data  out  8  tied 0.
- mem_data_in_ready  out  1  one-cycle request strobe.
- mem_fifo_full  in  1  arbiter backpressure for this port.
- mem_data_out  in  8  returned byte.
- mem_data_out_ready  in  1  this port's bit of the arbiter return-valid bus.
- disp_row_valid  out  1  display bank holds a complete row.
- disp_row  out  clog2(ROWS)  row index of the display bank.
- disp_rd_addr  in  clog2(ROW_BYTES)  byte index the display side reads.
- disp_rd_data  out  8  byte from the display bank.
- disp_row_done  in  1  one-cycle pulse: display has released its bank.
- frame_done  out  1  one-cycle pulse when the last row of a frame completes.

## Operation
- Reset values: every output 0; state IDLE; fill_bank=0; row=0; req_idx=0; ret_idx=0; outstanding=0.
- States:
  - IDLE: on enable=1, go to FETCH at row 0 and latch row_base=frame_base.
  - FETCH: issue requests and collect returns for the current row.
  - WAIT_BANK: the row is filled and the display still holds the other bank.
- Request rule: in FETCH, set mem_data_in_ready=1 and mem_address=row_base+req_idx when all of the following hold:
  - req_idx<ROW_BYTES
  - outstanding<MAX_OUTSTANDING
  - mem_fifo_full=0
  - At most one request per cycle; req_idx increments on each issue.
- Credit accounting:
  - outstanding +1 on issue, -1 on return; issue and return in the same cycle leave it unchanged.
  - A return with outstanding=0 is ignored and must not write the buffer.
- Return path: each mem_data_out_ready writes mem_data_out to fill_bank[ret_idx], then ret_idx increments. Bytes return in request order.
- Row completion happens on the return with ret_idx=ROW_BYTES-1.
  - If disp_row_valid=0, or disp_row_done is asserted in the same cycle: swap banks, set disp_row_valid=1 and disp_row=row, then advance the row.
  - Otherwise go to WAIT_BANK and swap on disp_row_done.
- Row advance:
  - row_base += ROW_BYTES, modulo 2^ADDRESS_WIDTH.
  - req_idx and ret_idx reset to 0.
  - Row ROWS-1 wraps to 0: pulse frame_done, re-latch row_base=frame_base.
- disp_row_done with no pending swap clears disp_row_valid on the next edge.
- enable deasserted mid-row: the current row completes, since reads cannot be cancelled. The FSM then goes to IDLE at the row boundary; the display bank is unaffected.
- The arbiter fifo_full lags by one cycle. The credit bound MAX_OUTSTANDING is the overflow guarantee; mem_fifo_full is an additional gate only.
- Reset mid-operation returns all state to reset values immediately. The arbiter must be reset in the same cycle, so stale returns cannot arrive.

## Timing
- Registered outputs: mem_address, mem_data_in_ready, disp_row_valid, disp_row, frame_done.
- First request: the cycle after the first edge in FETCH.
- disp_row_valid rises on the edge after the final byte return.
- disp_rd_data is registered: valid one cycle after disp_rd_addr, from the current display bank.
- A bank swap takes effect for reads issued on the cycle after the swap edge.
- Steady-state throughput is one request per cycle when the arbiter returns one byte per cycle and does not assert mem_fifo_full.

## Test plan
- Reset, enable=1, frame_base=0x100, arbiter model with 3-cycle fixed latency:
  - requests go to 0x100..0x1BF in order;
  - outstanding never exceeds 4;
  - disp_row_valid=1 with disp_row=0;
  - display readback of byte 5 returns the model value at 0x105.
- Hold mem_fifo_full=1 for 10 cycles mid-row:
  - no mem_data_in_ready while it is high;
  - requests resume at the next index with no gap or duplicate.
- Display never pulses disp_row_done:
  - row 1 fills, FSM sits in WAIT_BANK, no further requests;
  - one disp_row_done pulse gives disp_row=1 and row 2 fetch begins.
- Run 32 rows with frame_base=0x1FFFFC0:
  - frame_done pulses exactly once after row 31;
  - row addresses wrap modulo 2^25;
  - row 0 of the next frame starts at the re-latched frame_base.
- Drop enable mid-row 3: row 3 completes, then IDLE with no requests.
- Assert reset mid-row 2: every output 0 the next cycle; state restarts cleanly at row 0 on enable.
